// File: rtl/fsm_seq_detect_pkg.sv
// Shared definitions for the serial "10011" pattern detector.
//   state_e : binary-encoded sequence-progress states (3 bits, two codes unused)
//   PATTERN : the detected bit pattern, oldest bit in the MSB
package fsm_seq_detect_pkg;

  localparam int unsigned PatternLen = 5;
  localparam logic [PatternLen-1:0] PATTERN = 5'b10011;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StS1    = 3'd1,
    StS10   = 3'd2,
    StS100  = 3'd3,
    StS1001 = 3'd4,
    StDet   = 3'd5
  } state_e;

endpackage

// File: rtl/fsm_seq_detect.sv
// Serial bit-stream detector for the overlapping pattern 1,0,0,1,1 (oldest first).
// Ports:
//   CLK   - system clock, rising-edge active
//   RST   - synchronous active-high reset
//   IN    - serial data bit, sampled every rising edge
//   MATCH - registered one-cycle detect flag, high the cycle after the state reaches StDet
module fsm_seq_detect
  import fsm_seq_detect_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic IN,
  output logic MATCH
);

  state_e state_q, state_d;
  logic   match_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Registered from the current state, so MATCH never sees IN combinationally.
      match_q <= (state_q == StDet);
    end
  end

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:  state_d = IN ? StS1    : StIdle;
      StS1:    state_d = IN ? StS1    : StS10;
      StS10:   state_d = IN ? StS1    : StS100;
      StS100:  state_d = IN ? StS1001 : StIdle;
      StS1001: state_d = IN ? StDet   : StS10;
      // The trailing 1 of a completed pattern starts the next one.
      StDet:   state_d = IN ? StS1    : StS10;
      default: state_d = StIdle;
    endcase
  end

  assign MATCH = match_q;

endmodule

// File: tb/tb_fsm_seq_detect.sv
// Scoreboard bench for fsm_seq_detect: the driver pushes the expected MATCH for each
// edge into a queue, the monitor pops and compares one entry after every rising edge.
module tb_fsm_seq_detect;
  import fsm_seq_detect_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic IN  = 1'b0;
  logic MATCH;

  fsm_seq_detect dut (
    .CLK   (CLK),
    .RST   (RST),
    .IN    (IN),
    .MATCH (MATCH)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic  exp;
    string tag;
  } sb_item_t;

  sb_item_t sb[$];
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference: last five post-reset bits; MATCH follows the match one edge later.
  logic [4:0] hist  = 5'b0;
  logic       det_q = 1'b0;

  // Monitor
  initial begin
    sb_item_t it;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        checks++;
        if (MATCH !== it.exp) begin
          errors++;
          $display("FAIL %s: MATCH=%b expected %b at %0t", it.tag, MATCH, it.exp, $time);
        end
        if (MATCH === 1'b1) pulses++;
      end
    end
  end

  task automatic step(input logic b, input logic r, input string tag);
    sb_item_t it;
    @(negedge CLK);
    IN  = b;
    RST = r;
    it.exp = r ? 1'b0 : det_q;
    it.tag = tag;
    sb.push_back(it);
    if (r) begin
      hist  = 5'b0;
      det_q = 1'b0;
    end else begin
      hist  = {hist[3:0], b};
      det_q = (hist == PATTERN);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(posedge CLK);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Applies len bits of v, MSB first.
  task automatic run_bits(input logic [31:0] v, input int len, input string tag);
    for (int i = len - 1; i >= 0; i--) step(v[i], 1'b0, tag);
  endtask

  task automatic reset_dut(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, "reset");
  endtask

  task automatic check_pulses(input int exp, input string tag);
    drain();
    checks++;
    if (pulses != exp) begin
      errors++;
      $display("FAIL %s: pulses=%0d expected %0d", tag, pulses, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset with IN unknown
    for (int i = 0; i < 3; i++) step(1'bx, 1'b1, "reset_x");
    drain();
    checks++;
    if (dut.state_q !== StIdle) begin
      errors++;
      $display("FAIL reset_state: state=%0d expected %0d", dut.state_q, StIdle);
    end

    // 2. Basic: 000110011 then IN held high; one pulse two edges after the last 1
    pulses = 0;
    run_bits(32'b0_0011_0011, 9, "basic");
    run_bits(32'b111, 3, "basic_hold");
    check_pulses(1, "pulses_basic");

    // 3. Overlap: two pulses, 4 cycles apart
    reset_dut(2);
    pulses = 0;
    run_bits(32'b1_0011_0011, 9, "overlap");
    run_bits(32'b00, 2, "overlap_tail");
    check_pulses(2, "pulses_overlap");

    // 4. Near misses
    reset_dut(2);
    pulses = 0;
    run_bits(32'b10_0011, 6, "near_a");
    reset_dut(1);
    run_bits(32'b1_0111, 5, "near_b");
    run_bits(32'b00, 2, "near_tail");
    check_pulses(0, "pulses_near");

    // 5. Reset mid-pattern discards progress
    reset_dut(2);
    pulses = 0;
    run_bits(32'b1001, 4, "mid");
    reset_dut(1);
    run_bits(32'b1, 1, "mid_after");
    run_bits(32'b00, 2, "mid_after_tail");
    check_pulses(0, "pulses_mid_none");
    run_bits(32'b1_0011, 5, "mid_full");
    run_bits(32'b00, 2, "mid_full_tail");
    check_pulses(1, "pulses_mid_full");

    // 6. Random stream against the shift-register reference
    reset_dut(2);
    for (int i = 0; i < 1000; i++) step(1'($urandom_range(0, 1)), 1'b0, "random");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
